pacman_game_ctrl: RTL and testbench



---
 rtl/pacman_game_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pacman_game_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pacman_game_ctrl.sv
// Game sequencer for the Pac-Man core: owns core reset and step enable,
// accepts player moves over valid/ready, tracks lives, score and win/loss.
module pacman_game_ctrl #(
  parameter int WIDTH        = 8,
  parameter int HEIGHT       = 8,
  parameter int LIVES        = 3,
  parameter int RST_CYCLES   = 2,
  parameter int DEATH_CYCLES = 4,
  parameter int STEP_TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      move_valid,
  output logic                      move_ready,
  input  logic [1:0]                move_in,
  input  logic                      core_catch,
  input  logic [WIDTH*HEIGHT-1:0]   core_candies,
  output logic                      core_rst,
  output logic                      core_en,
  output logic [1:0]                core_move,
  output logic [3:0]                lives,
  output logic [15:0]               score,
  output logic [2:0]                state,
  output logic                      game_over,
  output logic                      game_won
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N + 1);
  localparam int TW = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST_CORE  = 3'd1,
    S_SETTLE    = 3'd2,
    S_PLAY      = 3'd3,
    S_DYING     = 3'd4,
    S_GAME_OVER = 3'd5,
    S_WON       = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic [CW-1:0]   cnt_prev_q, cnt_prev_d;
  logic [CW-1:0]   cnt_cur;
  logic [1:0]      last_move_q, last_move_d;
  logic [3:0]      lives_q, lives_d;
  logic [15:0]     score_q, score_d;
  logic            core_rst_q, core_rst_d;
  logic            core_en_q, core_en_d;
  logic [1:0]      core_move_q, core_move_d;
  logic            move_ready_q, move_ready_d;
  logic            game_over_q, game_over_d;
  logic            game_won_q, game_won_d;
  logic            accept;
  logic            step;
  logic [1:0]      step_move;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Next-state, counters and next registered outputs
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idle_d      = idle_q;
    cnt_prev_d  = cnt_prev_q;
    last_move_d = last_move_q;
    lives_d     = lives_q;
    score_d     = score_q;
    step        = 1'b0;
    step_move   = last_move_q;
    cnt_cur     = popcount(core_candies);
    accept      = move_valid && move_ready_q;

    case (state_q)
      S_IDLE, S_GAME_OVER, S_WON: begin
        if (start) begin
          state_d = S_RST_CORE;
          lives_d = 4'(LIVES);
          score_d = '0;
          timer_d = TW'(RST_CYCLES - 1);
        end
      end
      S_RST_CORE: begin
        if (timer_q == '0) state_d = S_SETTLE;
        else               timer_d = timer_q - 1'b1;
      end
      S_SETTLE: begin
        cnt_prev_d = cnt_cur;
        idle_d     = '0;
        state_d    = S_PLAY;
      end
      S_PLAY: begin
        cnt_prev_d = cnt_cur;
        if (cnt_cur < cnt_prev_q) score_d = sat_add(score_q, cnt_prev_q - cnt_cur);
        // Idle cycles are only those where a move could have been taken
        if (accept) begin
          last_move_d = move_in;
          step        = 1'b1;
          step_move   = move_in;
          idle_d      = '0;
        end else if (!core_en_q) begin
          if (idle_q == TW'(STEP_TIMEOUT - 1)) begin
            step   = 1'b1;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        // A catch outranks clearing the board in the same cycle
        if (core_catch) begin
          lives_d = lives_q - 4'd1;
          state_d = S_DYING;
          timer_d = TW'(DEATH_CYCLES - 1);
        end else if (cnt_cur == '0) begin
          state_d = S_WON;
        end
      end
      S_DYING: begin
        if (timer_q == '0) begin
          if (lives_q != 4'd0) begin
            state_d = S_RST_CORE;
            timer_d = TW'(RST_CYCLES - 1);
          end else begin
            state_d = S_GAME_OVER;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_rst_d   = (state_d == S_IDLE) || (state_d == S_RST_CORE);
    core_en_d    = step && (state_d == S_PLAY);
    core_move_d  = core_en_d ? step_move : core_move_q;
    move_ready_d = (state_d == S_PLAY) && !core_en_d;
    game_over_d  = (state_d == S_GAME_OVER);
    game_won_d   = (state_d == S_WON);
  end

  // State, counters and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      idle_q       <= '0;
      cnt_prev_q   <= '0;
      last_move_q  <= 2'b00;
      lives_q      <= 4'(LIVES);
      score_q      <= '0;
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      core_move_q  <= 2'b00;
      move_ready_q <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idle_q       <= idle_d;
      cnt_prev_q   <= cnt_prev_d;
      last_move_q  <= last_move_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      core_rst_q   <= core_rst_d;
      core_en_q    <= core_en_d;
      core_move_q  <= core_move_d;
      move_ready_q <= move_ready_d;
      game_over_q  <= game_over_d;
      game_won_q   <= game_won_d;
    end
  end

  assign state      = state_q;
  assign core_rst   = core_rst_q;
  assign core_en    = core_en_q;
  assign core_move  = core_move_q;
  assign move_ready = move_ready_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign game_over  = game_over_q;
  assign game_won   = game_won_q;

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Randomized bench for pacman_game_ctrl with a behavioural game model and a
// toy core that eats candies and raises catches in response to steps.
module tb_pacman_game_ctrl;

  localparam int LIVES        = 3;
  localparam int RST_CYCLES   = 2;
  localparam int DEATH_CYCLES = 4;
  localparam int STEP_TIMEOUT = 8;

  localparam int M_IDLE = 0, M_RSTC = 1, M_SETTLE = 2, M_PLAY = 3;
  localparam int M_DYING = 4, M_OVER = 5, M_WON = 6;

  logic        clk, rst, start, move_valid, move_ready, core_catch;
  logic [1:0]  move_in, core_move;
  logic [63:0] core_candies, init_map;
  logic        core_rst, core_en, game_over, game_won;
  logic [3:0]  lives;
  logic [15:0] score;
  logic [2:0]  state;

  pacman_game_ctrl #(
    .WIDTH(8), .HEIGHT(8), .LIVES(LIVES), .RST_CYCLES(RST_CYCLES),
    .DEATH_CYCLES(DEATH_CYCLES), .STEP_TIMEOUT(STEP_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid),
    .move_ready(move_ready), .move_in(move_in), .core_catch(core_catch),
    .core_candies(core_candies), .core_rst(core_rst), .core_en(core_en),
    .core_move(core_move), .lives(lives), .score(score), .state(state),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Game model: phase, cycles left in timed phases, ready cycles without a move
  int m_mode, m_left, m_quiet, m_last, m_lives, m_score, m_prev, m_move;
  bit m_en, m_ready;
  bit quiet_phase;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_quiet = 0; m_last = 0; m_lives = LIVES;
    m_score = 0; m_prev = 0; m_move = 0; m_en = 0; m_ready = 0;
  endtask

  task automatic model_clock();
    int cnt;
    bit nstep;
    int nmove;
    cnt = $countones(core_candies);
    nstep = 0;
    nmove = 0;
    case (m_mode)
      M_IDLE, M_OVER, M_WON:
        if (start) begin
          m_mode = M_RSTC; m_left = RST_CYCLES; m_lives = LIVES; m_score = 0;
        end
      M_RSTC: begin
        m_left--;
        if (m_left == 0) m_mode = M_SETTLE;
      end
      M_SETTLE: begin
        m_prev = cnt; m_quiet = 0; m_mode = M_PLAY;
      end
      M_PLAY: begin
        if (move_valid && m_ready) begin
          m_last = move_in; nstep = 1; nmove = move_in; m_quiet = 0;
        end else if (m_ready) begin
          m_quiet++;
          if (m_quiet == STEP_TIMEOUT) begin
            nstep = 1; nmove = m_last; m_quiet = 0;
          end
        end
        if (cnt < m_prev) begin
          m_score = m_score + (m_prev - cnt);
          if (m_score > 65535) m_score = 65535;
        end
        m_prev = cnt;
        if (core_catch) begin
          m_lives--; m_mode = M_DYING; m_left = DEATH_CYCLES;
        end else if (cnt == 0) begin
          m_mode = M_WON;
        end
      end
      M_DYING: begin
        m_left--;
        if (m_left == 0) m_mode = (m_lives > 0) ? M_RSTC : M_OVER;
        if (m_left == 0 && m_lives > 0) m_left = RST_CYCLES;
      end
      default: m_mode = M_IDLE;
    endcase
    m_en = nstep && (m_mode == M_PLAY);
    if (m_en) m_move = nmove;
    m_ready = (m_mode == M_PLAY) && !m_en;
  endtask

  task automatic check_all();
    check_eq("state", int'(state), m_mode);
    check_eq("core_rst", int'(core_rst), int'(m_mode == M_IDLE || m_mode == M_RSTC));
    check_eq("core_en", int'(core_en), int'(m_en));
    check_eq("move_ready", int'(move_ready), int'(m_ready));
    check_eq("lives", int'(lives), m_lives);
    check_eq("score", int'(score), m_score);
    check_eq("game_over", int'(game_over), int'(m_mode == M_OVER));
    check_eq("game_won", int'(game_won), int'(m_mode == M_WON));
    if (m_en) check_eq("core_move", int'(core_move), m_move);
  endtask

  task automatic eat(input int k);
    int off;
    int done;
    off = $urandom_range(0, 63);
    done = 0;
    for (int i = 0; i < 64 && done < k; i++) begin
      int p;
      p = (off + i) % 64;
      if (core_candies[p]) begin
        core_candies[p] = 1'b0;
        done++;
      end
    end
  endtask

  // Toy core: restores its map under reset, eats candies and may catch on steps
  task automatic core_update();
    if (m_mode == M_IDLE || m_mode == M_RSTC) begin
      core_candies = init_map;
      core_catch = 1'b0;
    end else if (m_en) begin
      if ($urandom_range(0, 99) < 70) eat($urandom_range(1, 4));
      if ($urandom_range(0, 29) == 0) core_catch = 1'b1;
      else if (core_candies == '0 && $urandom_range(0, 2) == 0) core_catch = 1'b1;
    end
  endtask

  task automatic drive_inputs(input int cyc);
    if (cyc % 40 == 0) quiet_phase = ($urandom_range(0, 9) < 4);
    move_valid = quiet_phase ? 1'b0 : ($urandom_range(0, 1) == 1);
    move_in    = 2'($urandom_range(0, 3));
    start      = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    clk = 0; rst = 0; start = 0; move_valid = 0; move_in = 0; core_catch = 0;
    quiet_phase = 0;
    init_map = '0;
    while ($countones(init_map) < 31) init_map[$urandom_range(0, 63)] = 1'b1;
    core_candies = init_map;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk); #1;
      model_clock();
      check_all();
      if (cyc == 2500 || cyc == 4500) begin
        rst = 0;
        #2;
        model_reset();
        check_all();
        core_update();
        @(posedge clk); #1;
        check_all();
        rst = 1;
      end else begin
        core_update();
        drive_inputs(cyc);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
